textbuf_slave: RTL and testbench
================================

# textbuf_slave

Wishbone responder that owns the 80x25 text framebuffer and cursor registers scanned by the VGA text driver. It answers the driver's back-to-back 40-word row bursts at one word per cycle and accepts CPU writes through the same port. It drives the cursor outputs consumed by the text renderer. It also runs a background fill engine that clears or paints the whole screen without stalling the bus.

## Interface
- WORDS, 1000, number of 32-bit framebuffer words (2 chars/word, 80x25)
- AWIDTH, 10, word-index width; 2^AWIDTH >= WORDS
- RESET_COLOR, 24'hffffff, reset value of cursorcolor
- clk_i  in  1  system/bus clock
- rst_i  in  1  reset; asynchronous, active-high
- cursorpos  out  32  cursor position register
- cursormode  out  4  cursor mode register
- cursorcolor  out  24  cursor colour register
- fill_busy  out  1  fill engine active
- bus  if_wb.slave  —  cyc, stb, we, sel[3:0], adr[31:0], dat_i/dat_o[31:0], ack; no stall

## Operation
- A request is valid when cyc && stb, sampled at a rising edge; every valid cycle is accepted, and there is no stall.
- Decode:
  - adr[12]=0: framebuffer, word index adr[AWIDTH+1:2].
  - adr[12]=1: registers at adr[4:2].
  - 0 cursorpos (RW).
  - 1 cursormode (RW, bits 3:0; read zero-extended).
  - 2 cursorcolor (RW, bits 23:0).
  - 3 FILL: a write starts a fill with dat_i as the fill word; a read returns {31'h0, fill_busy}.
  - 4–7 read 0, writes ignored.
- Framebuffer word index >= WORDS: write ignored, read returns 0, ack still given.
- Writes are byte-lane masked by sel for both framebuffer and registers; FILL takes all 32 bits regardless of sel.
- Framebuffer: single-port synchronous RAM, 32 x WORDS, contents not reset; byte offsets follow {rgb0, char0, rgb1, char1} packing.
- Fill engine FSM:
  - F_IDLE -> F_RUN on a FILL write while idle; latch the fill word and set fill_idx = 0.
  - In F_RUN, on each cycle with no valid bus request to the framebuffer region (register accesses do not block), write the fill word at fill_idx and increment fill_idx.
  - After writing index WORDS-1, go to F_IDLE.
  - A FILL write while busy is ignored; it is acked and does not restart the fill.
- Bus framebuffer accesses always win the RAM port; a fill never corrupts a same-cycle bus write.
- Reads during a fill return current RAM contents, which may be a mix of old data and fill data.

## Timing
- ack is asserted exactly one cycle after each accepted request, for reads and writes; N consecutive stb cycles give N consecutive acks in order.
- Read data is valid on dat_o in the ack cycle and is 0 in non-ack cycles.
- ack is never asserted without a preceding request; if cyc drops, in-flight acks still complete.
- Register writes take effect on the accepting edge, so the outputs change in the ack cycle.
- Read-after-write to the same address in consecutive cycles returns the new data.
- Fill duration is WORDS cycles when the bus is idle; each cycle blocked by a framebuffer request extends it by one.
- fill_busy rises in the ack cycle of the FILL write and falls the cycle after index WORDS-1 is written.
- Reset values:
  - ack=0, dat_o=0, cursorpos=0, cursormode=0, cursorcolor=RESET_COLOR.
  - fill_busy=0, FSM=F_IDLE, fill_idx=0.
- Reset asserted mid-fill aborts the fill immediately; a partially filled RAM is acceptable.
- Reset asserted mid-burst drops all pending acks.

## Test plan
- Burst read: preload words 0–39 with 0x0100_0000+i, then issue 40 consecutive stb reads at 0x0..0x9C -> 40 consecutive acks starting one cycle later, dat_o = 0x0100_0000+i in order.
- Byte-masked write: write 0xAABBCCDD at 0x10 with sel=4'b0101 over 0x11223344 -> read back 0x11BB33DD.
- Registers: write cursorpos=0x0000_0C2A, cursormode=0xF with sel=1, cursorcolor=0x12345678 -> outputs 0x0C2A, 4'hF, 24'h345678 in the ack cycle; readback of cursormode gives 0x0000000F.
- Idle fill: write FILL=0x0720_0720 -> fill_busy for exactly WORDS=1000 cycles; every word reads 0x0720_0720; status reads 0 afterward.
- Contended fill: start a fill, then issue 100 framebuffer writes of 0xDEADBEEF at word 999 interleaved with idle cycles -> fill takes 1100 cycles; word 999 ends as 0x0720_0720 (fill reached it last); no missing acks; a second FILL write mid-run is ignored.
- Edge cases: a read at word 1000 returns 0 with ack; asserting rst_i for 1 ns mid-fill immediately forces fill_busy=0 and ack=0.

Source files
------------

// File: rtl/textbuf_slave_if.sv
// Wishbone classic bus bundle between the text driver/CPU masters and the framebuffer slave.
// Ports: cyc, stb, we, sel[3:0], adr[31:0], dat_i (write data), dat_o (read data), ack.
// Named from the slave's side; there is no stall line because the slave takes every valid cycle.
`timescale 1ns/1ps
interface if_wb;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        ack;

    modport slave  (input cyc, stb, we, sel, adr, dat_i, output dat_o, ack);
    modport master (output cyc, stb, we, sel, adr, dat_i, input dat_o, ack);
endinterface

// File: rtl/textbuf_slave.sv
// Wishbone responder owning the 80x25 text framebuffer, cursor registers and a screen fill engine.
// Ports: clk_i/rst_i (async active-high), bus (if_wb slave), cursorpos/cursormode/cursorcolor, fill_busy.
// Every valid cycle is acked one cycle later with no stall; the fill engine only uses idle RAM cycles.
`timescale 1ns/1ps
module textbuf_slave #(
    parameter int          WORDS       = 1000,
    parameter int          AWIDTH      = 10,
    parameter logic [23:0] RESET_COLOR = 24'hffffff
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] cursorpos,
    output logic [3:0]  cursormode,
    output logic [23:0] cursorcolor,
    output logic        fill_busy,
    if_wb.slave         bus
);
    typedef enum logic {F_IDLE, F_RUN} fill_state_t;

    localparam logic [AWIDTH-1:0] LAST_IDX = AWIDTH'(WORDS - 1);

    function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  sel);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

    // request decode
    logic              req_vld;
    logic              req_reg;
    logic              req_fb;
    logic [AWIDTH-1:0] fb_idx;
    logic              fb_in_range;
    logic [2:0]        reg_idx;
    logic              fill_start;

    assign req_vld     = bus.cyc && bus.stb;
    assign req_reg     = bus.adr[12];
    assign req_fb      = req_vld && !req_reg;
    assign fb_idx      = bus.adr[AWIDTH+1:2];
    assign fb_in_range = (fb_idx <= LAST_IDX);
    assign reg_idx     = bus.adr[4:2];
    assign fill_start  = req_vld && req_reg && bus.we && (reg_idx == 3'd3);

    logic unused_adr_bits;
    assign unused_adr_bits = &{1'b0, bus.adr[31:13], bus.adr[1:0]};

    // state
    fill_state_t       fill_state_q;
    logic [AWIDTH-1:0] fill_idx_q;
    logic [31:0]       fill_word_q;
    logic              fill_busy_q;
    logic              ack_q;
    logic              rd_fb_q;
    logic [31:0]       reg_rd_q;
    logic [31:0]       cursorpos_q;
    logic [3:0]        cursormode_q;
    logic [23:0]       cursorcolor_q;

    // RAM port arbitration: any bus framebuffer request owns the port, even an
    // out-of-range one, so the fill only advances on cycles the bus leaves free.
    logic              ram_we;
    logic              ram_re;
    logic [3:0]        ram_be;
    logic [AWIDTH-1:0] ram_addr;
    logic [31:0]       ram_wdat;
    logic              fill_wr;

    always_comb begin
        ram_we   = 1'b0;
        ram_re   = 1'b0;
        ram_be   = 4'h0;
        ram_addr = fb_idx;
        ram_wdat = bus.dat_i;
        fill_wr  = 1'b0;
        if (req_fb) begin
            if (fb_in_range) begin
                ram_we = bus.we;
                ram_re = !bus.we;
                ram_be = bus.sel;
            end
        end else if (fill_state_q == F_RUN) begin
            fill_wr  = 1'b1;
            ram_we   = 1'b1;
            ram_be   = 4'hF;
            ram_addr = fill_idx_q;
            ram_wdat = fill_word_q;
        end
    end

    // framebuffer: single-port synchronous RAM, contents deliberately not reset
    logic [31:0] mem [WORDS];
    logic [31:0] ram_q;

    always_ff @(posedge clk_i) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdat[8*b +: 8];
            end
        end
        if (ram_re) ram_q <= mem[ram_addr];
    end

    // register file read mux and byte-merged write values
    logic [31:0] reg_rdata;
    logic [31:0] pos_wr;
    logic [31:0] color_wr;

    assign pos_wr   = byte_merge(cursorpos_q, bus.dat_i, bus.sel);
    assign color_wr = byte_merge({8'h00, cursorcolor_q}, bus.dat_i, bus.sel);

    always_comb begin
        case (reg_idx)
            3'd0:    reg_rdata = cursorpos_q;
            3'd1:    reg_rdata = {28'h0, cursormode_q};
            3'd2:    reg_rdata = {8'h00, cursorcolor_q};
            3'd3:    reg_rdata = {31'h0, fill_busy_q};
            default: reg_rdata = 32'h0;
        endcase
    end

    // bus response and cursor registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_q         <= 1'b0;
            rd_fb_q       <= 1'b0;
            reg_rd_q      <= 32'h0;
            cursorpos_q   <= 32'h0;
            cursormode_q  <= 4'h0;
            cursorcolor_q <= RESET_COLOR;
        end else begin
            ack_q    <= req_vld;
            rd_fb_q  <= ram_re;
            reg_rd_q <= 32'h0;
            if (req_vld && req_reg) begin
                if (bus.we) begin
                    case (reg_idx)
                        3'd0:    cursorpos_q <= pos_wr;
                        3'd1:    if (bus.sel[0]) cursormode_q <= bus.dat_i[3:0];
                        3'd2:    cursorcolor_q <= color_wr[23:0];
                        default: ;
                    endcase
                end else begin
                    reg_rd_q <= reg_rdata;
                end
            end
        end
    end

    // fill engine
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fill_state_q <= F_IDLE;
            fill_idx_q   <= '0;
            fill_word_q  <= 32'h0;
            fill_busy_q  <= 1'b0;
        end else begin
            case (fill_state_q)
                F_IDLE: begin
                    if (fill_start) begin
                        fill_state_q <= F_RUN;
                        fill_word_q  <= bus.dat_i;
                        fill_idx_q   <= '0;
                        fill_busy_q  <= 1'b1;
                    end
                end
                F_RUN: begin
                    // FILL writes arriving here are acked but otherwise ignored
                    if (fill_wr) begin
                        if (fill_idx_q == LAST_IDX) begin
                            fill_state_q <= F_IDLE;
                            fill_idx_q   <= '0;
                            fill_busy_q  <= 1'b0;
                        end else begin
                            fill_idx_q <= fill_idx_q + AWIDTH'(1);
                        end
                    end
                end
                default: fill_state_q <= F_IDLE;
            endcase
        end
    end

    // read data is forced to zero outside ack cycles
    assign bus.ack     = ack_q;
    assign bus.dat_o   = !ack_q ? 32'h0 : (rd_fb_q ? ram_q : reg_rd_q);
    assign cursorpos   = cursorpos_q;
    assign cursormode  = cursormode_q;
    assign cursorcolor = cursorcolor_q;
    assign fill_busy   = fill_busy_q;
endmodule

// File: tb/tb_textbuf_slave.sv
// Self-checking bench for textbuf_slave: directed plan items plus random bus traffic.
// A behavioural model (word array, register values, remaining-fill count) predicts every output.
// Outputs are compared on each falling edge; inputs change 1 ns after each rising edge.
`timescale 1ns/1ps
module tb_textbuf_slave;
    localparam int          WORDS       = 1000;
    localparam logic [23:0] RESET_COLOR = 24'hffffff;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] cursorpos;
    logic [3:0]  cursormode;
    logic [23:0] cursorcolor;
    logic        fill_busy;

    if_wb wb();

    textbuf_slave #(.WORDS(WORDS), .AWIDTH(10), .RESET_COLOR(RESET_COLOR)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .cursorpos  (cursorpos),
        .cursormode (cursormode),
        .cursorcolor(cursorcolor),
        .fill_busy  (fill_busy),
        .bus        (wb)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] bytemask(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] sel);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    // ---------------- behavioural model ----------------
    logic [31:0] m_mem   [WORDS];
    bit          m_known [WORDS];
    logic [31:0] m_pos       = 32'h0;
    logic [3:0]  m_mode      = 4'h0;
    logic [23:0] m_color     = RESET_COLOR;
    int          m_fill_left = 0;
    logic [31:0] m_fill_word = 32'h0;
    bit          e_ack       = 1'b0;
    logic [31:0] e_dat       = 32'h0;
    bit          e_dat_known = 1'b1;

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_pos = 32'h0; m_mode = 4'h0; m_color = RESET_COLOR;
            m_fill_left = 0; e_ack = 1'b0; e_dat = 32'h0; e_dat_known = 1'b1;
        end else begin : step
            bit v, fb, was_busy;
            int idx, ridx;
            logic [31:0] tmp;
            v        = wb.cyc && wb.stb;
            fb       = (wb.adr[12] == 1'b0);
            idx      = int'(wb.adr[11:2]);
            ridx     = int'(wb.adr[4:2]);
            was_busy = (m_fill_left > 0);
            e_ack = v; e_dat = 32'h0; e_dat_known = 1'b1;
            if (v && !wb.we) begin
                if (fb) begin
                    if (idx < WORDS) begin e_dat = m_mem[idx]; e_dat_known = m_known[idx]; end
                end else begin
                    case (ridx)
                        0: e_dat = m_pos;
                        1: e_dat = {28'h0, m_mode};
                        2: e_dat = {8'h0, m_color};
                        3: e_dat = {31'h0, was_busy};
                        default: e_dat = 32'h0;
                    endcase
                end
            end
            // the fill paints the next word on any cycle the bus leaves the framebuffer alone
            if (was_busy && !(v && fb)) begin
                m_mem[WORDS - m_fill_left]   = m_fill_word;
                m_known[WORDS - m_fill_left] = 1'b1;
                m_fill_left--;
            end
            if (v && wb.we) begin
                if (fb) begin
                    if (idx < WORDS) begin
                        m_mem[idx] = bytemask(m_mem[idx], wb.dat_i, wb.sel);
                        if (wb.sel == 4'hF) m_known[idx] = 1'b1;
                    end
                end else begin
                    case (ridx)
                        0: m_pos = bytemask(m_pos, wb.dat_i, wb.sel);
                        1: if (wb.sel[0]) m_mode = wb.dat_i[3:0];
                        2: begin tmp = bytemask({8'h0, m_color}, wb.dat_i, wb.sel); m_color = tmp[23:0]; end
                        3: if (!was_busy) begin m_fill_left = WORDS; m_fill_word = wb.dat_i; end
                        default: ;
                    endcase
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [31:0] acked[$];
    int ack_count   = 0;
    int busy_cycles = 0;

    always @(negedge clk_i) begin
        check("ack", 32'(wb.ack), 32'(e_ack));
        if (e_dat_known) check("dat_o", wb.dat_o, e_dat);
        check("cursorpos", cursorpos, m_pos);
        check("cursormode", 32'(cursormode), 32'(m_mode));
        check("cursorcolor", 32'(cursorcolor), 32'(m_color));
        check("fill_busy", 32'(fill_busy), 32'(m_fill_left > 0));
        if (wb.ack) begin acked.push_back(wb.dat_o); ack_count++; end
        if (fill_busy) busy_cycles++;
    end

    // ---------------- drivers ----------------
    task automatic drive(input bit c, input bit s, input bit w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] sl);
        wb.cyc = c; wb.stb = s; wb.we = w; wb.adr = a; wb.dat_i = d; wb.sel = sl;
        @(posedge clk_i); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] sl);
        drive(1'b1, 1'b1, 1'b1, a, d, sl);
    endtask

    task automatic rd(input logic [31:0] a);
        drive(1'b1, 1'b1, 1'b0, a, 32'h0, 4'hF);
    endtask

    task automatic read_word(input logic [31:0] a, output logic [31:0] d, output logic k);
        rd(a);
        wb.cyc = 1'b0; wb.stb = 1'b0;
        @(negedge clk_i); d = wb.dat_o; k = wb.ack;
        @(posedge clk_i); #1;
    endtask

    task automatic wait_fill_done(input string name);
        int n;
        n = 0;
        while (fill_busy && n < 3000) begin idle(1); n++; end
        check(name, 32'(fill_busy), 32'h0);
    endtask

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

    // ---------------- directed + random stimulus ----------------
    initial begin
        logic [31:0] d;
        logic        k;
        int base, bad, t0, a0;

        wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0; wb.adr = 32'h0; wb.dat_i = 32'h0; wb.sel = 4'h0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_ack", 32'(wb.ack), 32'h0);
        check("rst_dat", wb.dat_o, 32'h0);
        check("rst_pos", cursorpos, 32'h0);
        check("rst_mode", 32'(cursormode), 32'h0);
        check("rst_color", 32'(cursorcolor), 32'h00ffffff);
        check("rst_busy", 32'(fill_busy), 32'h0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        idle(2);

        // burst read of 40 preloaded words
        for (int i = 0; i < 40; i++) wr(32'(i * 4), 32'h0100_0000 + 32'(i), 4'hF);
        idle(1);
        base = acked.size();
        for (int i = 0; i < 40; i++) rd(32'(i * 4));
        idle(2);
        check("burst_count", 32'(acked.size() - base), 32'd40);
        bad = 0;
        for (int i = 0; i < 40; i++) if (acked[base + i] !== 32'h0100_0000 + 32'(i)) bad++;
        check("burst_data_bad", 32'(bad), 32'h0);

        // byte-masked write
        wr(32'h10, 32'h1122_3344, 4'hF);
        wr(32'h10, 32'hAABB_CCDD, 4'b0101);
        read_word(32'h10, d, k);
        check("bytemask_data", d, 32'h11BB_33DD);
        check("bytemask_ack", 32'(k), 32'h1);

        // registers visible in the ack cycle
        wr(32'h1000, 32'h0000_0C2A, 4'hF);
        check("reg_pos", cursorpos, 32'h0000_0C2A);
        wr(32'h1004, 32'h0000_000F, 4'h1);
        check("reg_mode", 32'(cursormode), 32'hF);
        wr(32'h1008, 32'h1234_5678, 4'hF);
        check("reg_color", 32'(cursorcolor), 32'h0034_5678);
        idle(1);
        read_word(32'h1004, d, k);
        check("reg_mode_rd", d, 32'h0000_000F);

        // idle fill
        t0 = busy_cycles;
        wr(32'h100C, 32'h0720_0720, 4'h1);
        wait_fill_done("fill_idle_done");
        check("fill_idle_cycles", 32'(busy_cycles - t0), 32'd1000);
        base = acked.size();
        for (int i = 0; i < WORDS; i++) rd(32'(i * 4));
        idle(2);
        check("fill_read_count", 32'(acked.size() - base), 32'd1000);
        bad = 0;
        for (int i = 0; i < WORDS; i++) if (acked[base + i] !== 32'h0720_0720) bad++;
        check("fill_words_bad", 32'(bad), 32'h0);
        read_word(32'h100C, d, k);
        check("fill_status_after", d, 32'h0);

        // contended fill with a second FILL write mid-run
        t0 = busy_cycles;
        a0 = ack_count;
        wr(32'h100C, 32'h0720_0720, 4'hF);
        for (int i = 0; i < 100; i++) begin
            wr(32'(999 * 4), 32'hDEAD_BEEF, 4'hF);
            if (i == 50) wr(32'h100C, 32'h1111_1111, 4'hF);
            else idle(1);
        end
        wait_fill_done("fill_cont_done");
        idle(2);
        check("fill_cont_cycles", 32'(busy_cycles - t0), 32'd1100);
        check("fill_cont_acks", 32'(ack_count - a0), 32'd102);
        read_word(32'(999 * 4), d, k);
        check("fill_word999", d, 32'h0720_0720);
        read_word(32'h0, d, k);
        check("fill_second_ignored", d, 32'h0720_0720);

        // out-of-range framebuffer and unused registers
        wr(32'hFA0, 32'h1234_5678, 4'hF);
        read_word(32'hFA0, d, k);
        check("oor_data", d, 32'h0);
        check("oor_ack", 32'(k), 32'h1);
        wr(32'h1014, 32'hFFFF_FFFF, 4'hF);
        read_word(32'h1014, d, k);
        check("reg5_data", d, 32'h0);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] a;
            bit c, s, w;
            c = ($urandom_range(0, 9) != 0);
            s = ($urandom_range(0, 5) != 0);
            w = 1'($urandom_range(0, 1));
            a = $urandom;
            a[12] = ($urandom_range(0, 9) < 3);
            drive(c, s, w, a, $urandom, 4'($urandom_range(0, 15)));
        end
        idle(2);
        wait_fill_done("rand_fill_done");

        // reset mid-fill with a read ack in flight
        wr(32'h100C, 32'hA5A5_A5A5, 4'hF);
        idle(10);
        rd(32'h0);
        wb.cyc = 1'b0; wb.stb = 1'b0;
        check("pre_rst_ack", 32'(wb.ack), 32'h1);
        #1 rst_i = 1'b1;
        #0.5;
        check("mid_rst_ack", 32'(wb.ack), 32'h0);
        check("mid_rst_busy", 32'(fill_busy), 32'h0);
        check("mid_rst_dat", wb.dat_o, 32'h0);
        check("mid_rst_color", 32'(cursorcolor), 32'h00ffffff);
        #0.5 rst_i = 1'b0;
        @(posedge clk_i); #1;
        idle(2);
        read_word(32'h100C, d, k);
        check("post_rst_status", d, 32'h0);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
